// File: rtl/ring_pointer_ctrl_if.sv
// ring_pointer_ctrl_if: request/accept handshake and pointer/status bundle for ring_pointer_ctrl
//   master: drives clear, wr_en, rd_en; observes accepts, pointers, count and flags
//   slave : the pointer controller, drives wr_acc, rd_acc, wr_ptr, rd_ptr, count,
//           empty, full, almost_full, overflow, underflow
interface ring_pointer_ctrl_if #(
    parameter int BufferWidth = 2
) ();
    logic                   clear;
    logic                   wr_en;
    logic                   rd_en;
    logic                   wr_acc;
    logic                   rd_acc;
    logic [BufferWidth-1:0] wr_ptr;
    logic [BufferWidth-1:0] rd_ptr;
    logic [BufferWidth:0]   count;
    logic                   empty;
    logic                   full;
    logic                   almost_full;
    logic                   overflow;
    logic                   underflow;
    modport master (
        output clear, wr_en, rd_en,
        input  wr_acc, rd_acc, wr_ptr, rd_ptr, count,
        input  empty, full, almost_full, overflow, underflow
    );
    modport slave (
        input  clear, wr_en, rd_en,
        output wr_acc, rd_acc, wr_ptr, rd_ptr, count,
        output empty, full, almost_full, overflow, underflow
    );
endinterface

// File: rtl/ring_pointer_ctrl.sv
// ring_pointer_ctrl: paired write/read pointer controller for a DEPTH-entry ring buffer
//   clk     : clock, all state on posedge
//   reset_n : synchronous reset, active low
//   bus     : slave side of ring_pointer_ctrl_if (clear/wr_en/rd_en in; combinational
//             wr_acc/rd_acc; registered wr_ptr, rd_ptr, count, empty, full,
//             almost_full, sticky overflow/underflow)
module ring_pointer_ctrl #(
    parameter int BufferWidth = 2,
    parameter int DEPTH       = 4,
    parameter int AF_LEVEL    = DEPTH - 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ring_pointer_ctrl_if.slave   bus
);
    localparam int CntWidth = BufferWidth + 1;
    localparam logic [BufferWidth-1:0] LastIdx = BufferWidth'(DEPTH - 1);
    localparam logic [CntWidth-1:0]    FullCnt = CntWidth'(DEPTH);
    localparam logic [CntWidth-1:0]    AfCnt   = CntWidth'(AF_LEVEL);
    logic [CntWidth-1:0]    count_nxt;
    logic [BufferWidth-1:0] wr_ptr_nxt;
    logic [BufferWidth-1:0] rd_ptr_nxt;
    // A write on full is only admitted when a read frees the slot in the same cycle.
    assign bus.rd_acc = bus.rd_en & ~bus.empty & ~bus.clear;
    assign bus.wr_acc = bus.wr_en & ~bus.clear & (~bus.full | bus.rd_acc);
    // Wrap at DEPTH-1 so non-power-of-two depths work.
    assign wr_ptr_nxt = (bus.wr_ptr == LastIdx) ? '0 : bus.wr_ptr + 1'b1;
    assign rd_ptr_nxt = (bus.rd_ptr == LastIdx) ? '0 : bus.rd_ptr + 1'b1;
    assign count_nxt  = (bus.wr_acc & ~bus.rd_acc) ? bus.count + 1'b1 :
                        (~bus.wr_acc & bus.rd_acc) ? bus.count - 1'b1 : bus.count;
    // Flags are derived from the next count so they line up with the registered count.
    always_ff @(posedge clk) begin
        if (!reset_n || bus.clear) begin
            bus.wr_ptr      <= '0;
            bus.rd_ptr      <= '0;
            bus.count       <= '0;
            bus.empty       <= 1'b1;
            bus.full        <= 1'b0;
            bus.almost_full <= 1'b0;
            bus.overflow    <= 1'b0;
            bus.underflow   <= 1'b0;
        end else begin
            if (bus.wr_acc) bus.wr_ptr <= wr_ptr_nxt;
            if (bus.rd_acc) bus.rd_ptr <= rd_ptr_nxt;
            bus.count       <= count_nxt;
            bus.empty       <= count_nxt == '0;
            bus.full        <= count_nxt == FullCnt;
            bus.almost_full <= count_nxt >= AfCnt;
            if (bus.wr_en & ~bus.wr_acc) bus.overflow <= 1'b1;
            if (bus.rd_en & bus.empty) bus.underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ring_pointer_ctrl.sv
// tb_ring_pointer_ctrl: table-driven check of ring_pointer_ctrl at DEPTH=3 and DEPTH=4
module tb_ring_pointer_ctrl;
    logic clk = 1'b0;
    logic rst3_n = 1'b1;
    logic rst4_n = 1'b1;
    int   nvec = 0;
    int   nmis = 0;
    always #5 clk = ~clk;
    ring_pointer_ctrl_if #(.BufferWidth(2)) i3 ();
    ring_pointer_ctrl_if #(.BufferWidth(2)) i4 ();
    ring_pointer_ctrl #(.BufferWidth(2), .DEPTH(3)) u3 (.clk(clk), .reset_n(rst3_n), .bus(i3.slave));
    ring_pointer_ctrl #(.BufferWidth(2), .DEPTH(4), .AF_LEVEL(3)) u4 (.clk(clk), .reset_n(rst4_n), .bus(i4.slave));
    // observed state: {wr_ptr, rd_ptr, count, empty, full, almost_full, overflow, underflow}
    wire [11:0] obs3 = {i3.wr_ptr, i3.rd_ptr, i3.count, i3.empty, i3.full, i3.almost_full, i3.overflow, i3.underflow};
    wire [11:0] obs4 = {i4.wr_ptr, i4.rd_ptr, i4.count, i4.empty, i4.full, i4.almost_full, i4.overflow, i4.underflow};
    wire [1:0]  acc3 = {i3.wr_acc, i3.rd_acc};
    wire [1:0]  acc4 = {i4.wr_acc, i4.rd_acc};
    typedef struct {
        logic       rst_n, clr, wr, rd, chk_acc;
        logic [1:0] acc;
        logic [11:0] st;
    } vec_t;
    vec_t v[19];
    function automatic logic [11:0] st(input int wp, rp, c, e, f, a, o, u);
        return {2'(wp), 2'(rp), 3'(c), 1'(e), 1'(f), 1'(a), 1'(o), 1'(u)};
    endfunction
    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step(input int d, input vec_t t, input string name);
        @(negedge clk);
        if (d == 3) begin
            rst3_n = t.rst_n; i3.clear = t.clr; i3.wr_en = t.wr; i3.rd_en = t.rd;
        end else begin
            rst4_n = t.rst_n; i4.clear = t.clr; i4.wr_en = t.wr; i4.rd_en = t.rd;
        end
        #1;
        if (t.chk_acc) chk({name, " acc"}, 12'(d == 3 ? acc3 : acc4), 12'(t.acc));
        @(posedge clk);
        #1;
        chk({name, " state"}, d == 3 ? obs3 : obs4, t.st);
    endtask
    initial begin
        i3.clear = 0; i3.wr_en = 0; i3.rd_en = 0;
        i4.clear = 0; i4.wr_en = 0; i4.rd_en = 0;
        v[0]  = '{0, 0, 1, 1, 0, 2'b00, st(0, 0, 0, 1, 0, 0, 0, 0)};
        v[1]  = '{1, 0, 1, 0, 1, 2'b10, st(1, 0, 1, 0, 0, 0, 0, 0)};
        v[2]  = '{1, 0, 1, 0, 1, 2'b10, st(2, 0, 2, 0, 0, 1, 0, 0)};
        v[3]  = '{1, 0, 1, 0, 1, 2'b10, st(0, 0, 3, 0, 1, 1, 0, 0)};
        v[4]  = '{1, 0, 1, 0, 1, 2'b00, st(0, 0, 3, 0, 1, 1, 1, 0)};
        v[5]  = '{1, 0, 0, 1, 1, 2'b01, st(0, 1, 2, 0, 0, 1, 1, 0)};
        v[6]  = '{1, 0, 0, 1, 1, 2'b01, st(0, 2, 1, 0, 0, 0, 1, 0)};
        v[7]  = '{1, 0, 0, 1, 1, 2'b01, st(0, 0, 0, 1, 0, 0, 1, 0)};
        v[8]  = '{1, 0, 0, 1, 1, 2'b00, st(0, 0, 0, 1, 0, 0, 1, 1)};
        v[9]  = '{1, 0, 1, 1, 1, 2'b10, st(1, 0, 1, 0, 0, 0, 1, 1)};
        v[10] = '{1, 0, 1, 0, 1, 2'b10, st(2, 0, 2, 0, 0, 1, 1, 1)};
        v[11] = '{1, 0, 1, 0, 1, 2'b10, st(0, 0, 3, 0, 1, 1, 1, 1)};
        v[12] = '{1, 0, 1, 1, 1, 2'b11, st(1, 1, 3, 0, 1, 1, 1, 1)};
        v[13] = '{1, 0, 0, 1, 1, 2'b01, st(1, 2, 2, 0, 0, 1, 1, 1)};
        v[14] = '{1, 1, 1, 0, 1, 2'b00, st(0, 0, 0, 1, 0, 0, 0, 0)};
        v[15] = '{1, 0, 0, 0, 1, 2'b00, st(0, 0, 0, 1, 0, 0, 0, 0)};
        v[16] = '{1, 0, 1, 0, 1, 2'b10, st(1, 0, 1, 0, 0, 0, 0, 0)};
        v[17] = '{0, 0, 1, 1, 0, 2'b00, st(0, 0, 0, 1, 0, 0, 0, 0)};
        v[18] = '{1, 1, 0, 1, 1, 2'b00, st(0, 0, 0, 1, 0, 0, 0, 0)};
        for (int i = 0; i < 19; i++) step(3, v[i], $sformatf("d3_v%0d", i));
        // DEPTH=4, AF_LEVEL=3: almost_full edge and wrap at 3
        step(4, '{0, 0, 1, 1, 0, 2'b00, st(0, 0, 0, 1, 0, 0, 0, 0)}, "d4_reset");
        step(4, '{1, 0, 1, 0, 1, 2'b10, st(1, 0, 1, 0, 0, 0, 0, 0)}, "d4_wr1");
        step(4, '{1, 0, 1, 0, 1, 2'b10, st(2, 0, 2, 0, 0, 0, 0, 0)}, "d4_wr2");
        step(4, '{1, 0, 1, 0, 1, 2'b10, st(3, 0, 3, 0, 0, 1, 0, 0)}, "d4_af_rise");
        step(4, '{1, 0, 0, 1, 1, 2'b01, st(3, 1, 2, 0, 0, 0, 0, 0)}, "d4_af_fall");
        step(4, '{1, 0, 1, 0, 1, 2'b10, st(0, 1, 3, 0, 0, 1, 0, 0)}, "d4_wrap");
        step(4, '{1, 0, 1, 0, 1, 2'b10, st(1, 1, 4, 0, 1, 1, 0, 0)}, "d4_full");
        step(4, '{1, 0, 1, 1, 1, 2'b11, st(2, 2, 4, 0, 1, 1, 0, 0)}, "d4_both_full");
        step(4, '{1, 0, 1, 0, 1, 2'b00, st(2, 2, 4, 0, 1, 1, 1, 0)}, "d4_ovf");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
